// File: rtl/fetch_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_exec_ctrl
// Purpose  : Multi-cycle sequencer for a single-cycle RV32 datapath. It fetches
//            one instruction at a time from instruction memory, presents it to
//            decode/execute for a single commit cycle, then fetches the next.
//            It halts on ebreak, traps on fetch faults, misaligned PCs and
//            response timeouts, and keeps cycle and retired-instruction counters.
// Ports    : clk, reset (async, active-low)
//            pc_in          - current PC from the datapath PC register
//            imem_req_*     - fetch request (valid/ready, address)
//            imem_rsp_*     - fetch response (valid pulse, data, fault)
//            halt_in        - datapath decoded ebreak on inst_out
//            inst_out/valid - latched instruction and its EXEC-cycle qualifier
//            commit_en      - one-cycle PC/regfile write enable
//            halted, error  - sticky terminal status
//            cycle_cnt      - cycles spent outside HALT/ERR
//            inst_cnt       - retired instructions
// Revision : 1.0 - initial release
// ============================================================================
module fetch_exec_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_in,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [31:0]      imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  input  logic             imem_rsp_err,
  input  logic             halt_in,
  output logic [31:0]      inst_out,
  output logic             inst_valid,
  output logic             commit_en,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] inst_cnt
);

  localparam logic [2:0] c_BOOT = 3'd0;
  localparam logic [2:0] c_REQ  = 3'd1;
  localparam logic [2:0] c_WAIT = 3'd2;
  localparam logic [2:0] c_EXEC = 3'd3;
  localparam logic [2:0] c_HALT = 3'd4;
  localparam logic [2:0] c_ERR  = 3'd5;

  localparam logic [TO_W-1:0] c_TIMEOUT = TO_W'(TIMEOUT);

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [TO_W-1:0]  r_to_cnt;
  logic [TO_W-1:0]  w_to_inc;
  logic             w_to_expired;
  logic             w_pc_aligned;
  logic [31:0]      r_inst;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_inst_cnt;

  assign w_pc_aligned = (pc_in[1:0] == 2'b00);
  assign w_to_inc     = r_to_cnt + 1'b1;
  // Expires on the cycle whose increment would reach TIMEOUT; a response
  // arriving in that same cycle still takes priority in the next-state logic.
  assign w_to_expired = (TIMEOUT != 0) && (w_to_inc == c_TIMEOUT);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_BOOT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_BOOT: w_next = c_REQ;
      c_REQ: begin
        if (!w_pc_aligned) begin
          w_next = c_ERR;
        end else if (imem_req_ready) begin
          w_next = c_WAIT;
        end
      end
      c_WAIT: begin
        if (imem_rsp_valid) begin
          w_next = imem_rsp_err ? c_ERR : c_EXEC;
        end else if (w_to_expired) begin
          w_next = c_ERR;
        end
      end
      c_EXEC: w_next = halt_in ? c_HALT : c_REQ;
      c_HALT: w_next = c_HALT;
      c_ERR:  w_next = c_ERR;
      default: w_next = c_ERR;
    endcase
  end

  // State-decoded outputs. The request is gated by alignment so a misaligned
  // PC never produces a visible request before the jump to ERR.
  always_comb begin
    imem_req_valid = (r_state == c_REQ) && w_pc_aligned;
    imem_req_addr  = pc_in;
    inst_valid     = (r_state == c_EXEC);
    commit_en      = (r_state == c_EXEC);
    halted         = (r_state == c_HALT);
    error          = (r_state == c_ERR);
  end

  // Timeout counter: held at zero outside WAIT, so it is clear on entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= '0;
    end else if (r_state != c_WAIT) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= w_to_inc;
    end
  end

  // Instruction latch and counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inst      <= '0;
      r_cycle_cnt <= '0;
      r_inst_cnt  <= '0;
    end else begin
      if ((r_state == c_WAIT) && imem_rsp_valid && !imem_rsp_err) begin
        r_inst <= imem_rsp_data;
      end
      if ((r_state != c_HALT) && (r_state != c_ERR)) begin
        r_cycle_cnt <= r_cycle_cnt + 1'b1;
      end
      if (r_state == c_EXEC) begin
        r_inst_cnt <= r_inst_cnt + 1'b1;
      end
    end
  end

  assign inst_out  = r_inst;
  assign cycle_cnt = r_cycle_cnt;
  assign inst_cnt  = r_inst_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_exec_ctrl
// Purpose  : Self-checking bench for fetch_exec_ctrl. An imem responder model
//            answers accepted requests and queues the expected commit; a
//            monitor pops the queue on every commit cycle. Directed checks
//            cover reset, timing, stalls, faults, timeout and halt.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_exec_ctrl;

  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [31:0] BASE   = 32'h80000000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_in = BASE;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        rsp_err = 1'b0;
  logic        halt_in;
  logic [31:0] inst_out;
  logic        inst_valid;
  logic        commit_en;
  logic        halted;
  logic        error;
  logic [31:0] cycle_cnt;
  logic [31:0] inst_cnt;

  int   n_chk = 0;
  int   n_err = 0;
  int   n_req = 0;
  int   exp_icnt = 0;
  int   lat = 1;
  bit   err_flag = 1'b0;
  bit   mute = 1'b0;
  exp_t sb[$];

  fetch_exec_ctrl #(.CNT_W(32), .TIMEOUT(4), .TO_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_in          (pc_in),
    .imem_req_valid (req_valid),
    .imem_req_ready (req_ready),
    .imem_req_addr  (req_addr),
    .imem_rsp_valid (rsp_valid),
    .imem_rsp_data  (rsp_data),
    .imem_rsp_err   (rsp_err),
    .halt_in        (halt_in),
    .inst_out       (inst_out),
    .inst_valid     (inst_valid),
    .commit_en      (commit_en),
    .halted         (halted),
    .error          (error),
    .cycle_cnt      (cycle_cnt),
    .inst_cnt       (inst_cnt)
  );

  always #5 clk = ~clk;

  // Datapath decode stand-in: ebreak is recognised on the presented word.
  assign halt_in = inst_valid && (inst_out == EBREAK);

  // Program image: word index 10 is ebreak, others are addi x0,x0,idx.
  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - BASE) >> 2;
    if (idx == 32'd10) return EBREAK;
    return {idx[11:0], 20'h00013};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // imem responder: answers each accepted request after 'lat' cycles.
  initial begin
    logic [31:0] a;
    bit          e;
    int          l;
    forever begin
      @(negedge clk);
      if (reset && req_valid && req_ready && !mute) begin
        a = req_addr;
        e = err_flag;
        l = lat;
        @(posedge clk);
        repeat (l - 1) @(posedge clk);
        #1;
        rsp_valid = 1'b1;
        rsp_data  = mem(a);
        rsp_err   = e;
        if (!e) begin
          sb.push_back('{inst: mem(a), cnt: exp_icnt});
          exp_icnt++;
        end
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
      end
    end
  end

  // PC register stand-in: advances after each non-halting commit.
  always @(negedge clk) begin
    if (reset && commit_en && !halt_in) begin
      @(posedge clk);
      #1 pc_in = pc_in + 32'd4;
    end
  end

  // Monitor: request count and scoreboard comparison on each commit.
  always @(negedge clk) begin
    if (reset && req_valid && req_ready) n_req++;
    if (reset && commit_en) begin
      chk("commit_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("commit_inst", inst_out, e.inst);
        chk("commit_inst_cnt", inst_cnt, e.cnt);
        chk("commit_inst_valid", inst_valid, 1);
      end
    end
  end

  task automatic do_reset(input logic [31:0] pc0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    pc_in    = pc0;
    sb.delete();
    exp_icnt = 0;
    n_req    = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_commit", commit_en, 0);
    chk("rst_status", {halted, error}, 0);
    chk("rst_counters", {cycle_cnt, inst_cnt}, 0);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // From the middle of cycle k to the middle of cycle k+n.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // ---- Sequence from reset, 10 instructions then ebreak ----
    req_ready = 1'b1; lat = 1; err_flag = 1'b0; mute = 1'b0;
    do_reset(BASE);
    @(negedge clk);
    chk("a_boot_req_valid", req_valid, 0);
    chk("a_boot_cycle_cnt", cycle_cnt, 0);
    cyc(1);
    chk("a_c1_req_valid", req_valid, 1);
    chk("a_c1_req_addr", req_addr, BASE);
    chk("a_c1_cycle_cnt", cycle_cnt, 1);
    cyc(2);
    chk("a_c3_commit", commit_en, 1);
    cyc(1);
    chk("a_c4_inst_cnt", inst_cnt, 1);
    chk("a_c4_commit", commit_en, 0);
    for (int i = 0; i < 200 && !halted; i++) @(negedge clk);
    chk("a_halted", halted, 1);
    chk("a_inst_cnt", inst_cnt, 11);
    chk("a_error", error, 0);
    chk("a_cycle_cnt", cycle_cnt, 34);
    cyc(5);
    chk("a_cycle_frozen", cycle_cnt, 34);
    chk("a_req_after_halt", req_valid, 0);
    chk("a_req_total", n_req, 11);
    chk("a_sb_empty", sb.size(), 0);

    // ---- Request stall: ready low for 5 cycles ----
    req_ready = 1'b0;
    do_reset(BASE);
    @(negedge clk);
    for (int c = 1; c <= 5; c++) begin
      cyc(1);
      chk("b_stall_req_valid", req_valid, 1);
      chk("b_stall_req_addr", req_addr, BASE);
    end
    @(posedge clk);
    #1 req_ready = 1'b1;
    @(posedge clk);
    #1 req_ready = 1'b0;
    @(negedge clk);
    cyc(5);
    chk("b_req_total", n_req, 1);
    chk("b_inst_cnt", inst_cnt, 1);
    chk("b_next_req_valid", req_valid, 1);
    chk("b_next_req_addr", req_addr, BASE + 32'd4);
    chk("b_sb_empty", sb.size(), 0);
    reset = 1'b0;
    #1;
    chk("b_reset_drops_req", req_valid, 0);

    // ---- Fetch fault ----
    req_ready = 1'b1; err_flag = 1'b1;
    do_reset(BASE);
    @(negedge clk);
    cyc(3);
    chk("c_error", error, 1);
    chk("c_halted", halted, 0);
    chk("c_cycle_cnt", cycle_cnt, 3);
    cyc(5);
    chk("c_cycle_frozen", cycle_cnt, 3);
    chk("c_req_valid", req_valid, 0);
    chk("c_req_total", n_req, 1);
    chk("c_inst_cnt", inst_cnt, 0);
    err_flag = 1'b0;

    // ---- Timeout with no response ----
    mute = 1'b1;
    do_reset(BASE);
    @(negedge clk);
    cyc(5);
    chk("d_no_error_yet", error, 0);
    cyc(1);
    chk("d_timeout_error", error, 1);
    chk("d_cycle_cnt", cycle_cnt, 6);

    // ---- Response on the last allowed WAIT cycle ----
    mute = 1'b0; lat = 4; req_ready = 1'b1;
    do_reset(BASE);
    repeat (2) @(posedge clk);
    #1 req_ready = 1'b0;
    @(negedge clk);
    cyc(4);
    chk("d2_commit", commit_en, 1);
    chk("d2_error", error, 0);
    cyc(1);
    chk("d2_inst_cnt", inst_cnt, 1);
    chk("d2_error_after", error, 0);
    chk("d2_sb_empty", sb.size(), 0);
    lat = 1;

    // ---- Misaligned PC, then asynchronous reset ----
    req_ready = 1'b1;
    do_reset(BASE + 32'd2);
    @(negedge clk);
    cyc(1);
    chk("e_req_valid_c1", req_valid, 0);
    cyc(1);
    chk("e_error", error, 1);
    chk("e_req_valid_c2", req_valid, 0);
    chk("e_cycle_cnt", cycle_cnt, 2);
    chk("e_req_total", n_req, 0);
    reset = 1'b0;
    #1;
    chk("e_async_status", {halted, error}, 0);
    chk("e_async_outputs", {req_valid, commit_en, inst_valid}, 0);
    chk("e_async_counters", {cycle_cnt, inst_cnt}, 0);
    chk("e_async_inst_out", inst_out, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
`default_nettype wire
